// File: rtl/shift_ctrl_pkg.sv
// Shared encodings for the serializer controller: FSM states, shift direction
// codes and the gap-counter reload helper.
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam logic DIR_MSB = 1'b0;
  localparam logic DIR_LSB = 1'b1;

  // The gap counter counts down to zero, so a gap of G cycles reloads with G-1.
  // A zero gap never enters the gap state; the reload value is then unused.
  function automatic logic [3:0] gap_reload(input int gap);
    return (gap > 0) ? 4'(gap - 1) : 4'd0;
  endfunction

endpackage

// File: rtl/shift_core.sv
// N-bit shift register with parallel load and one-bit zero-filled shift.
// dir_i=0 shifts left (MSB leaves first), dir_i=1 shifts right (LSB leaves
// first). Load wins over shift when both are requested.
module shift_core
  import shift_ctrl_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic         dir_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  // Next value: load, else shift in the requested direction, else hold.
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = d_i;
    end else if (shift_i) begin
      q_d = (dir_i == DIR_LSB) ? {1'b0, q_q[N-1:1]} : {q_q[N-2:0], 1'b0};
    end
  end

  // Register update with asynchronous clear.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/shift_tx_ctrl.sv
// Serializer controller: accepts N-bit words on a valid/ready handshake and
// emits them one bit per accepted transfer, MSB-first or LSB-first as latched
// at load time. All outputs decode from registers, so there is no
// combinational path from any input to any output.
module shift_tx_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int N   = 8,
  parameter int GAP = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  input  logic         lsb_first,
  output logic         in_ready,
  output logic         sout,
  output logic         sout_valid,
  input  logic         sout_ready,
  output logic         sout_last,
  output logic         busy,
  output logic         done
);

  localparam int              CNT_W    = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [3:0]      GAP_LOAD = gap_reload(GAP);
  localparam bit              HAS_GAP  = (GAP > 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             dir_q,   dir_d;
  logic [3:0]       gap_q,   gap_d;
  logic             done_q,  done_d;

  logic             load;
  logic             xfer;
  logic [N-1:0]     shreg;

  // A transfer only happens while a bit is actually being presented.
  assign xfer = (state_q == ST_SHIFT) && sout_ready;

  shift_core #(.N(N)) u_core (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .shift_i (xfer),
    .dir_i   (dir_q),
    .d_i     (in_data),
    .q_o     (shreg)
  );

  // Next-state, counter and done-pulse decode.
  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          dir_d   = lsb_first;
          cnt_d   = CNT_LAST;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (xfer) begin
          if (cnt_q == '0) begin
            done_d = 1'b1;
            if (HAS_GAP) begin
              state_d = ST_GAP;
              gap_d   = GAP_LOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == 4'd0) state_d = ST_IDLE;
        else               gap_d   = gap_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers; reset aborts any frame in flight immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_MSB;
      gap_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign sout_valid = (state_q == ST_SHIFT);
  assign sout       = (dir_q == DIR_LSB) ? shreg[0] : shreg[N-1];
  assign sout_last  = (state_q == ST_SHIFT) && (cnt_q == '0);
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_shift_tx_ctrl.sv
// Directed bench for shift_tx_ctrl (N=8). Two instances share stimulus:
// one with GAP=1, one with GAP=0; use_g0 selects which one is driven/observed.
module tb_shift_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       lsb_first = 1'b0;
  logic       sout_ready = 1'b0;
  logic       use_g0 = 1'b0;

  logic in_valid1, in_ready1, sout1, sout_valid1, sout_last1, busy1, done1;
  logic in_valid0, in_ready0, sout0, sout_valid0, sout_last0, busy0, done0;

  assign in_valid1 = in_valid & ~use_g0;
  assign in_valid0 = in_valid &  use_g0;

  shift_tx_ctrl #(.N(8), .GAP(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data),
    .lsb_first(lsb_first), .in_ready(in_ready1), .sout(sout1),
    .sout_valid(sout_valid1), .sout_ready(sout_ready), .sout_last(sout_last1),
    .busy(busy1), .done(done1)
  );

  shift_tx_ctrl #(.N(8), .GAP(0)) dut_g0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_data(in_data),
    .lsb_first(lsb_first), .in_ready(in_ready0), .sout(sout0),
    .sout_valid(sout_valid0), .sout_ready(sout_ready), .sout_last(sout_last0),
    .busy(busy0), .done(done0)
  );

  logic in_ready_m, sout_m, sout_valid_m, sout_last_m, busy_m, done_m;
  assign in_ready_m   = use_g0 ? in_ready0   : in_ready1;
  assign sout_m       = use_g0 ? sout0       : sout1;
  assign sout_valid_m = use_g0 ? sout_valid0 : sout_valid1;
  assign sout_last_m  = use_g0 ? sout_last0  : sout_last1;
  assign busy_m       = use_g0 ? busy0       : busy1;
  assign done_m       = use_g0 ? done0       : done1;

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One word with sout_ready held high. exp_seq[7] is the first bit expected.
  // flip_at >= 0 inverts lsb_first after that bit index is observed.
  task automatic run_word(input logic [7:0] data, input logic lsb,
                          input logic [7:0] exp_seq, input int gap, input int flip_at);
    check("idle_in_ready", 32'(in_ready_m), 32'd1);
    in_data = data; lsb_first = lsb; in_valid = 1'b1; sout_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("bit_valid", 32'(sout_valid_m), 32'd1);
      check("bit_value", 32'(sout_m), 32'(exp_seq[7-i]));
      check("bit_last", 32'(sout_last_m), 32'(i == 7));
      check("bit_in_ready", 32'(in_ready_m), 32'd0);
      if (i == flip_at) lsb_first = ~lsb_first;
      @(negedge clk);
    end
    check("done_pulse", 32'(done_m), 32'd1);
    check("post_valid", 32'(sout_valid_m), 32'd0);
    check("post_in_ready", 32'(in_ready_m), 32'(gap == 0));
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      check("gap_done_low", 32'(done_m), 32'd0);
      check("gap_in_ready", 32'(in_ready_m), 32'(g == gap - 1));
    end
    if (gap == 0) @(negedge clk);
  endtask

  // in_valid held high: first word 0xC4, then 0x5A offered continuously.
  task automatic back_to_back(input int period);
    int         acc[3];
    int         n_acc;
    logic [7:0] cap;
    bit         seen;
    n_acc = 0; cap = 8'h00;
    in_data = 8'hC4; lsb_first = 1'b0; sout_ready = 1'b1; in_valid = 1'b1;
    for (int c = 0; c <= 2 * period; c++) begin
      if (c == 1) in_data = 8'h5A;
      if (in_ready_m && in_valid) begin
        if (n_acc < 3) acc[n_acc] = c;
        n_acc++;
      end
      if (c >= period + 1 && c <= period + 8) cap = {cap[6:0], sout_m};
      if (c == 2 * period) in_valid = 1'b0;
      @(negedge clk);
    end
    check("b2b_accepts", 32'(n_acc), 32'd3);
    check("b2b_acc0", 32'(acc[0]), 32'd0);
    check("b2b_acc1", 32'(acc[1]), 32'(period));
    check("b2b_acc2", 32'(acc[2]), 32'(2 * period));
    check("b2b_word2", 32'(cap), 32'h5A);
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      if (in_ready_m) seen = 1'b1;
    end
    check("b2b_drain", 32'(seen), 32'd1);
  endtask

  // Backpressure: sout_ready follows 1,0,0,1 repeating.
  task automatic backpressure();
    logic [3:0] pat;
    logic [7:0] exp_seq;
    int         xfers, dones;
    logic       prev_hold, prev_sout, prev_last;
    pat = 4'b1001; exp_seq = 8'hC4;
    xfers = 0; dones = 0; prev_hold = 1'b0; prev_sout = 1'b0; prev_last = 1'b0;
    in_data = 8'hC4; lsb_first = 1'b0; sout_ready = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done_m) dones++;
      if (prev_hold) begin
        check("bp_sout_hold", 32'(sout_m), 32'(prev_sout));
        check("bp_last_hold", 32'(sout_last_m), 32'(prev_last));
      end
      sout_ready = pat[3 - (c % 4)];
      prev_hold  = sout_valid_m && !sout_ready;
      prev_sout  = sout_m;
      prev_last  = sout_last_m;
      if (sout_valid_m && sout_ready) begin
        if (xfers < 8) begin
          check("bp_bit", 32'(sout_m), 32'(exp_seq[7 - xfers]));
          check("bp_last", 32'(sout_last_m), 32'(xfers == 7));
        end
        xfers++;
      end
      @(negedge clk);
    end
    check("bp_xfers", 32'(xfers), 32'd8);
    check("bp_dones", 32'(dones), 32'd1);
    check("bp_idle", 32'(in_ready_m), 32'd1);
    sout_ready = 1'b1;
  endtask

  // Reset after three bits have transferred.
  task automatic reset_midword();
    logic [7:0] exp_seq;
    int         dones;
    exp_seq = 8'hC4; dones = 0;
    in_data = 8'hC4; lsb_first = 1'b0; sout_ready = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst_pre_bit", 32'(sout_m), 32'(exp_seq[7-i]));
      @(negedge clk);
    end
    #1 rst = 1'b1;
    #1;
    check("rst_sout_valid", 32'(sout_valid_m), 32'd0);
    check("rst_in_ready", 32'(in_ready_m), 32'd1);
    check("rst_busy", 32'(busy_m), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (done_m || sout_valid_m) dones++;
      @(negedge clk);
    end
    check("rst_no_activity", 32'(dones), 32'd0);
    run_word(8'hFF, 1'b0, 8'hFF, 1, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    #12;
    check("reset_in_ready", 32'(in_ready1), 32'd1);
    check("reset_sout_valid", 32'(sout_valid1), 32'd0);
    check("reset_sout", 32'(sout1), 32'd0);
    check("reset_sout_last", 32'(sout_last1), 32'd0);
    check("reset_busy", 32'(busy1), 32'd0);
    check("reset_done", 32'(done1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // MSB-first and LSB-first of 0xC4.
    run_word(8'hC4, 1'b0, 8'hC4, 1, -1);
    run_word(8'hC4, 1'b1, 8'h23, 1, -1);

    backpressure();
    back_to_back(10);
    reset_midword();

    // Direction flip mid-word keeps MSB order (0xC4), next word goes LSB (0x23).
    run_word(8'hC4, 1'b0, 8'hC4, 1, 3);
    check("flip_latched", 32'(lsb_first), 32'd1);
    run_word(8'hC4, 1'b1, 8'h23, 1, -1);

    // GAP=0 instance.
    use_g0 = 1'b1;
    @(negedge clk);
    run_word(8'hC4, 1'b0, 8'hC4, 0, -1);
    back_to_back(9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
